apu_frame_sequencer: RTL and testbench

APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

---
 rtl/apu_frame_sequencer.sv | 97 +++++++++
 tb/tb_apu_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 512 Hz step generator with per-channel
// length counters and volume envelopes.
module apu_frame_sequencer #(
  parameter int CLK_DIV = 24000,
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       trigger,
  input  logic [NUM_CH-1:0]       dont_loop,
  input  logic [NUM_CH*LEN_W-1:0] length_data,
  input  logic [NUM_CH*4-1:0]     init_vol,
  input  logic [NUM_CH-1:0]       env_inc,
  input  logic [NUM_CH*3-1:0]     env_period,
  output logic [2:0]              step,
  output logic                    tick_len,
  output logic                    tick_sweep,
  output logic                    tick_env,
  output logic [NUM_CH-1:0]       on_flag,
  output logic [NUM_CH*4-1:0]     volume
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(CLK_DIV - 1);
  localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  logic [PW-1:0] presc;
  logic          wrap;
  logic [2:0]    nxt_step;

  logic [LEN_W:0] len_cnt   [NUM_CH];
  logic [3:0]     env_vol   [NUM_CH];
  logic [2:0]     env_timer [NUM_CH];

  assign wrap     = (presc == DIV_M1);
  assign nxt_step = step + 3'd1;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      presc      <= '0;
      step       <= '0;
      tick_len   <= 1'b0;
      tick_sweep <= 1'b0;
      tick_env   <= 1'b0;
    end else begin
      presc      <= wrap ? '0 : presc + 1'b1;
      tick_len   <= wrap && !nxt_step[0];
      tick_sweep <= wrap && (nxt_step[1:0] == 2'b10);
      tick_env   <= wrap && (nxt_step == 3'd7);
      if (wrap)
        step <= nxt_step;
    end
  end

  // A trigger reloads the channel and swallows any tick on that edge.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      on_flag <= '0;
      volume  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        len_cnt[i]   <= '0;
        env_vol[i]   <= '0;
        env_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        volume[i*4 +: 4] <= on_flag[i] ? env_vol[i] : 4'd0;
        if (trigger[i]) begin
          on_flag[i]   <= 1'b1;
          len_cnt[i]   <= LEN_FULL - {1'b0, length_data[i*LEN_W +: LEN_W]};
          env_vol[i]   <= init_vol[i*4 +: 4];
          env_timer[i] <= env_period[i*3 +: 3];
        end else begin
          if (tick_len && on_flag[i] && dont_loop[i]) begin
            len_cnt[i] <= len_cnt[i] - 1'b1;
            if (len_cnt[i] == {{LEN_W{1'b0}}, 1'b1})
              on_flag[i] <= 1'b0;
          end
          if (tick_env && (env_period[i*3 +: 3] != 3'd0)) begin
            if (env_timer[i] <= 3'd1) begin
              env_timer[i] <= env_period[i*3 +: 3];
              if (env_inc[i] && (env_vol[i] != 4'd15))
                env_vol[i] <= env_vol[i] + 4'd1;
              else if (!env_inc[i] && (env_vol[i] != 4'd0))
                env_vol[i] <= env_vol[i] - 4'd1;
            end else begin
              env_timer[i] <= env_timer[i] - 3'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: directed literal checks plus
// randomized traffic against a behavioural model.
module tb_apu_frame_sequencer;

  localparam int CD = 4;
  localparam int NC = 4;
  localparam int LW = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [NC-1:0]    trigger;
  logic [NC-1:0]    dont_loop;
  logic [NC*LW-1:0] length_data;
  logic [NC*4-1:0]  init_vol;
  logic [NC-1:0]    env_inc;
  logic [NC*3-1:0]  env_period;
  logic [2:0]       step;
  logic             tick_len;
  logic             tick_sweep;
  logic             tick_env;
  logic [NC-1:0]    on_flag;
  logic [NC*4-1:0]  volume;

  apu_frame_sequencer #(
    .CLK_DIV(CD), .NUM_CH(NC), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .trigger(trigger), .dont_loop(dont_loop),
    .length_data(length_data), .init_vol(init_vol),
    .env_inc(env_inc), .env_period(env_period),
    .step(step), .tick_len(tick_len),
    .tick_sweep(tick_sweep), .tick_env(tick_env),
    .on_flag(on_flag), .volume(volume)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Behavioural model: step and strobes derive from the count of
  // consecutive enabled cycles; channels follow the documented rules.
  int  m_n;
  int  m_step;
  bit  m_tl, m_ts, m_te;
  bit  m_on  [NC];
  int  m_len [NC];
  int  m_vol [NC];
  int  m_tmr [NC];
  int  m_out [NC];
  bit  started = 0;

  always @(posedge clk) begin
    bit ptl, pte, wr;
    int s, ld, ep;
    logic [NC-1:0]   e_on;
    logic [NC*4-1:0] e_vol;
    ptl = m_tl;
    pte = m_te;
    if (reset) started = 1;
    if (reset || !enable) begin
      m_n = 0; m_step = 0;
      m_tl = 0; m_ts = 0; m_te = 0;
      for (int c = 0; c < NC; c++) begin
        m_on[c] = 0; m_len[c] = 0; m_vol[c] = 0;
        m_tmr[c] = 0; m_out[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        m_out[c] = m_on[c] ? m_vol[c] : 0;
        ep = int'(env_period[c*3 +: 3]);
        if (trigger[c]) begin
          ld = int'(length_data[c*LW +: LW]);
          m_on[c]  = 1;
          m_len[c] = (1 << LW) - ld;
          m_vol[c] = int'(init_vol[c*4 +: 4]);
          m_tmr[c] = ep;
        end else begin
          if (ptl && m_on[c] && dont_loop[c]) begin
            m_len[c]--;
            if (m_len[c] == 0) m_on[c] = 0;
          end
          if (pte && ep != 0) begin
            if (m_tmr[c] <= 1) begin
              m_tmr[c] = ep;
              if (env_inc[c]) m_vol[c] = (m_vol[c] < 15) ? m_vol[c] + 1 : 15;
              else            m_vol[c] = (m_vol[c] > 0) ? m_vol[c] - 1 : 0;
            end else begin
              m_tmr[c]--;
            end
          end
        end
      end
      m_n++;
      wr = (m_n % CD) == 0;
      s = (m_n / CD) % 8;
      m_step = s;
      m_tl = wr && (s % 2 == 0);
      m_ts = wr && (s == 2 || s == 6);
      m_te = wr && (s == 7);
    end
    #1;
    if (started) begin
      for (int c = 0; c < NC; c++) begin
        e_on[c] = m_on[c];
        e_vol[c*4 +: 4] = m_out[c][3:0];
      end
      check("step", 32'(step), 32'(m_step));
      check("tick_len", 32'(tick_len), 32'(m_tl));
      check("tick_sweep", 32'(tick_sweep), 32'(m_ts));
      check("tick_env", 32'(tick_env), 32'(m_te));
      check("on_flag", 32'(on_flag), 32'(e_on));
      check("volume", 32'(volume), 32'(e_vol));
    end
  end

  task automatic wait_tl();
    int k = 0;
    do begin @(negedge clk); k++; end while (!tick_len && k < 200);
    check("wait_tick_len_timeout", 32'(tick_len), 32'd1);
  endtask

  task automatic wait_te();
    int k = 0;
    do begin @(negedge clk); k++; end while (!tick_env && k < 200);
    check("wait_tick_env_timeout", 32'(tick_env), 32'd1);
  endtask

  task automatic cfg0(input logic [5:0] ld, input logic dl,
                      input logic [3:0] iv, input logic inc,
                      input logic [2:0] per);
    length_data[5:0] = ld;
    dont_loop[0]     = dl;
    init_vol[3:0]    = iv;
    env_inc[0]       = inc;
    env_period[2:0]  = per;
  endtask

  task automatic pulse_trig(input logic [NC-1:0] t);
    trigger = t;
    @(negedge clk);
    trigger = '0;
  endtask

  initial begin
    int tl_n, ts_n, te_n, k;
    reset = 1; enable = 0; trigger = '0; dont_loop = '0;
    length_data = '0; init_vol = '0; env_inc = '0; env_period = '0;
    repeat (3) @(negedge clk);
    check("rst_step", 32'(step), 32'd0);
    check("rst_on", 32'(on_flag), 32'd0);
    check("rst_vol", 32'(volume), 32'd0);

    // Eight steps in 32 cycles
    reset = 0; enable = 1;
    tl_n = 0; ts_n = 0; te_n = 0;
    repeat (32) begin
      @(negedge clk);
      tl_n += int'(tick_len);
      ts_n += int'(tick_sweep);
      te_n += int'(tick_env);
    end
    check("cnt_tick_len", 32'(tl_n), 32'd4);
    check("cnt_tick_sweep", 32'(ts_n), 32'd2);
    check("cnt_tick_env", 32'(te_n), 32'd1);
    check("step_wrapped", 32'(step), 32'd0);

    // Length 62 with the trigger landing on a tick_len edge
    cfg0(6'd62, 1'b1, 4'd9, 1'b0, 3'd0);
    pulse_trig(4'b0001);
    check("len_on_set", 32'(on_flag[0]), 32'd1);
    @(negedge clk);
    check("len_vol", 32'(volume[3:0]), 32'd9);
    wait_tl();
    @(negedge clk);
    check("len_on_after_1", 32'(on_flag[0]), 32'd1);
    wait_tl();
    @(negedge clk);
    check("len_on_after_2", 32'(on_flag[0]), 32'd0);
    @(negedge clk);
    check("len_vol_off", 32'(volume[3:0]), 32'd0);

    // Envelope saturation up and down
    cfg0(6'd0, 1'b0, 4'd14, 1'b1, 3'd1);
    pulse_trig(4'b0001);
    @(negedge clk);
    check("env_vol14", 32'(volume[3:0]), 32'd14);
    wait_te();
    repeat (2) @(negedge clk);
    check("env_vol15", 32'(volume[3:0]), 32'd15);
    wait_te();
    repeat (2) @(negedge clk);
    check("env_sat15", 32'(volume[3:0]), 32'd15);
    cfg0(6'd0, 1'b0, 4'd1, 1'b0, 3'd1);
    pulse_trig(4'b0001);
    @(negedge clk);
    check("env_vol1", 32'(volume[3:0]), 32'd1);
    wait_te();
    repeat (2) @(negedge clk);
    check("env_vol0", 32'(volume[3:0]), 32'd0);
    check("env_on_kept", 32'(on_flag[0]), 32'd1);

    // All channels on, then one cycle of enable low
    pulse_trig(4'b1111);
    check("all_on", 32'(on_flag), 32'hF);
    enable = 0; trigger = 4'b1111;
    @(negedge clk);
    check("dis_on", 32'(on_flag), 32'd0);
    check("dis_vol", 32'(volume), 32'd0);
    check("dis_step", 32'(step), 32'd0);
    enable = 1; trigger = '0;
    @(negedge clk);
    check("dis_trig_ignored", 32'(on_flag), 32'd0);

    // Reset mid-step with channels on
    pulse_trig(4'b1111);
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst2_on", 32'(on_flag), 32'd0);
    check("rst2_vol", 32'(volume), 32'd0);
    check("rst2_step", 32'(step), 32'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (!tick_len && k < 100);
    check("rst2_first_tl", 32'(k), 32'(2 * CD));

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 399) == 0);
      enable  = ($urandom_range(0, 149) != 0);
      for (int c = 0; c < NC; c++)
        trigger[c] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) begin
        dont_loop  = NC'($urandom);
        env_inc    = NC'($urandom);
        env_period = (NC*3)'($urandom);
        init_vol   = (NC*4)'($urandom);
        for (int c = 0; c < NC; c++)
          length_data[c*LW +: LW] = ($urandom_range(0, 1) != 0)
            ? LW'($urandom_range(58, 63)) : LW'($urandom);
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
